// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: stage-buffer state encoding and the per-boundary
// control/data widths with their bubble values.
package pipe_stage_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } pipe_state_e;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 96;
    localparam logic [IF_ID_CTRL_W-1:0] IF_ID_BUBBLE = '0;

    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 128;
    localparam logic [ID_EX_CTRL_W-1:0] ID_EX_BUBBLE = '0;

    localparam int EX_MEM_CTRL_W = 12;
    localparam int EX_MEM_DATA_W = 96;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_BUBBLE = '0;

    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready flow control, optional
// two-entry skid buffer, flush-to-bubble and saturating stall/flush counters.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                CTRL_W      = 16,
    parameter int                DATA_W      = 128,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter bit                SKID        = 1'b1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic              in_fire, out_fire, discard;

    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

    // Held in reset so upstream never sees the stage as ready before it is.
    generate
        if (SKID) begin : g_ready_reg
            assign in_ready = rst && (state_q != SKID_FULL);
        end else begin : g_ready_comb
            assign in_ready = rst && (!out_valid || out_ready);
        end
    endgenerate

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // A flush counts only if it actually drops something still owed downstream.
    assign discard = flush && ((state_q == SKID_FULL) ||
                               ((state_q == FULL) && !out_fire) ||
                               in_fire);

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d     = FULL;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (in_fire && SKID) begin
                    state_d     = SKID_FULL;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (out_fire) begin
                    state_d     = EMPTY;
                    main_ctrl_d = CTRL_BUBBLE;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    state_d     = FULL;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d     = EMPTY;
                main_ctrl_d = CTRL_BUBBLE;
            end
        endcase

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_ctrl_q <= CTRL_BUBBLE;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    // NOTE: the wide data registers are deliberately not reset; only control
    // decides validity, and the data path stays free of reset fan-out.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clr_n_i (rst),
        .en_i    (out_valid && !out_ready),
        .cnt_o   (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clr_n_i (rst),
        .en_i    (discard),
        .cnt_o   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid, no-skid and narrow-counter instances
// share one stimulus bus; each task checks the instance it targets.
module tb_pipe_stage_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, out_ready, flush;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;

    logic         a_in_ready, a_out_valid;
    logic [15:0]  a_out_ctrl, a_stall, a_flush;
    logic [127:0] a_out_data;

    logic         b_in_ready, b_out_valid;
    logic [15:0]  b_out_ctrl, b_stall, b_flush;
    logic [127:0] b_out_data;

    logic         c_in_ready, c_out_valid;
    logic [15:0]  c_out_ctrl;
    logic [3:0]   c_stall, c_flush;
    logic [127:0] c_out_data;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [15:0] B_BUBBLE = 16'hB0B0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_stage_buf #(.SKID(1'b0), .CTRL_BUBBLE(B_BUBBLE)) u_noskid (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    pipe_stage_buf #(.SKID(1'b1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .stall_cnt(c_stall), .flush_cnt(c_flush)
    );

    // Backpressure scenario table: inputs before each edge, outputs after it.
    localparam logic        BP_IV   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] BP_CTRL [7] = '{16'h0021, 16'h0022, 16'h0023, 16'h0023,
                                            16'h0023, 16'h0023, 16'h0000};
    localparam logic        BP_ORDY [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic        BP_XV   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] BP_XC   [7] = '{16'h0021, 16'h0021, 16'h0021, 16'h0021,
                                            16'h0022, 16'h0023, 16'h0000};
    localparam logic        BP_XRDY [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [15:0] BP_XST  [7] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = {8{c}};
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h0005, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0h exp 0", a_out_valid); end
        tests_run++; if (a_out_ctrl !== 16'h0000) begin tests_failed++; $display("FAIL reset_ctrl: got %0h exp 0", a_out_ctrl); end
        tests_run++; if (b_out_ctrl !== B_BUBBLE) begin tests_failed++; $display("FAIL reset_ctrl_noskid: got %0h exp %0h", b_out_ctrl, B_BUBBLE); end
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %0h exp 0", a_in_ready); end
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready_noskid: got %0h exp 0", b_in_ready); end
        tests_run++; if (a_stall !== 16'd0 || a_flush !== 16'd0) begin tests_failed++; $display("FAIL reset_counters: got %0h/%0h exp 0/0", a_stall, a_flush); end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %0h exp 1", a_in_ready); end
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready_noskid: got %0h exp 1", b_in_ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b1, 1'b0);
            #1;
            tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d]: got %0h exp 1", i, a_in_ready); end
            tick();
            tests_run++;
            if (a_out_valid !== 1'b1 || a_out_ctrl !== 16'(i) || a_out_data !== {8{16'(i)}}) begin
                tests_failed++;
                $display("FAIL stream_out[%0d]: got v=%0h ctrl=%0h exp v=1 ctrl=%0h", i, a_out_valid, a_out_ctrl, i);
            end
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tests_run++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0000) begin tests_failed++; $display("FAIL stream_drain: got v=%0h ctrl=%0h exp v=0 ctrl=0", a_out_valid, a_out_ctrl); end
        tests_run++; if (a_stall !== 16'd0) begin tests_failed++; $display("FAIL stream_stall: got %0d exp 0", a_stall); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(BP_IV[i], BP_CTRL[i], BP_ORDY[i], 1'b0);
            tick();
            tests_run++;
            if (a_out_valid !== BP_XV[i] || a_out_ctrl !== BP_XC[i] ||
                (BP_XV[i] && a_out_data !== {8{BP_XC[i]}})) begin
                tests_failed++;
                $display("FAIL bp_out[%0d]: got v=%0h ctrl=%0h exp v=%0h ctrl=%0h", i, a_out_valid, a_out_ctrl, BP_XV[i], BP_XC[i]);
            end
            tests_run++; if (a_in_ready !== BP_XRDY[i]) begin tests_failed++; $display("FAIL bp_in_ready[%0d]: got %0h exp %0h", i, a_in_ready, BP_XRDY[i]); end
            tests_run++; if (a_stall !== BP_XST[i]) begin tests_failed++; $display("FAIL bp_stall[%0d]: got %0d exp %0d", i, a_stall, BP_XST[i]); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 16'h0031, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0032, 1'b0, 1'b0);
        tick();
        tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_pre_skid_full: got %0h exp 0", a_in_ready); end
        drive(1'b1, 16'h0033, 1'b0, 1'b1);
        tick();
        tests_run++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0000) begin tests_failed++; $display("FAIL flush_bubble: got v=%0h ctrl=%0h exp v=0 ctrl=0", a_out_valid, a_out_ctrl); end
        tests_run++; if (a_flush !== 16'd1) begin tests_failed++; $display("FAIL flush_cnt: got %0d exp 1", a_flush); end
        tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %0h exp 1", a_in_ready); end
        tests_run++; if (a_out_data !== {8{16'h0031}}) begin tests_failed++; $display("FAIL flush_data_hold: got %0h exp %0h", a_out_data, {8{16'h0031}}); end
        tests_run++; if (a_stall !== 16'd2) begin tests_failed++; $display("FAIL flush_stall: got %0d exp 2", a_stall); end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tests_run++; if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_skid_dropped: got %0h exp 0", a_out_valid); end
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        tests_run++; if (a_flush !== 16'd1) begin tests_failed++; $display("FAIL flush_empty_nocount: got %0d exp 1", a_flush); end
        drive(1'b1, 16'h0034, 1'b1, 1'b0);
        tick();
        tests_run++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 16'h0034) begin tests_failed++; $display("FAIL flush_resume: got v=%0h ctrl=%0h exp v=1 ctrl=34", a_out_valid, a_out_ctrl); end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_noskid();
        do_reset();
        drive(1'b1, 16'h0041, 1'b1, 1'b0);
        tick();
        tests_run++; if (b_out_valid !== 1'b1 || b_out_ctrl !== 16'h0041) begin tests_failed++; $display("FAIL noskid_first: got v=%0h ctrl=%0h exp v=1 ctrl=41", b_out_valid, b_out_ctrl); end
        drive(1'b1, 16'h0042, 1'b0, 1'b0);
        #1;
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL noskid_ready_comb_low: got %0h exp 0", b_in_ready); end
        tick();
        tests_run++; if (b_out_ctrl !== 16'h0041 || b_stall !== 16'd1) begin tests_failed++; $display("FAIL noskid_hold: got ctrl=%0h stall=%0d exp ctrl=41 stall=1", b_out_ctrl, b_stall); end
        drive(1'b1, 16'h0042, 1'b1, 1'b0);
        #1;
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL noskid_ready_comb_high: got %0h exp 1", b_in_ready); end
        tick();
        tests_run++; if (b_out_ctrl !== 16'h0042) begin tests_failed++; $display("FAIL noskid_replace: got %0h exp 42", b_out_ctrl); end
        for (int k = 16'h43; k <= 16'h45; k++) begin
            drive(1'b1, 16'(k), 1'b1, 1'b0);
            tick();
            tests_run++;
            if (b_out_valid !== 1'b1 || b_out_ctrl !== 16'(k) || b_out_data !== {8{16'(k)}}) begin
                tests_failed++;
                $display("FAIL noskid_stream[%0h]: got v=%0h ctrl=%0h exp v=1 ctrl=%0h", k, b_out_valid, b_out_ctrl, k);
            end
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tests_run++; if (b_out_valid !== 1'b0 || b_out_ctrl !== B_BUBBLE) begin tests_failed++; $display("FAIL noskid_drain: got v=%0h ctrl=%0h exp v=0 ctrl=%0h", b_out_valid, b_out_ctrl, B_BUBBLE); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 16'h0051, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                tests_run++; if (c_stall !== 4'd14) begin tests_failed++; $display("FAIL sat_pre: got %0d exp 14", c_stall); end
            end
            if (i == 15) begin
                tests_run++; if (c_stall !== 4'd15) begin tests_failed++; $display("FAIL sat_reach: got %0d exp 15", c_stall); end
            end
        end
        tests_run++; if (c_stall !== 4'd15) begin tests_failed++; $display("FAIL sat_hold: got %0d exp 15", c_stall); end
        tests_run++; if (a_stall !== 16'd20) begin tests_failed++; $display("FAIL sat_wide: got %0d exp 20", a_stall); end
        tests_run++; if (a_out_ctrl !== 16'h0051 || a_out_data !== {8{16'h0051}}) begin tests_failed++; $display("FAIL sat_entry_hold: got %0h exp 51", a_out_ctrl); end
    endtask

    task automatic test_reset_clears();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tests_run++; if (a_stall !== 16'd0 || c_stall !== 4'd0) begin tests_failed++; $display("FAIL reclear_stall: got %0d/%0d exp 0/0", a_stall, c_stall); end
        tests_run++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0000) begin tests_failed++; $display("FAIL reclear_state: got v=%0h ctrl=%0h exp v=0 ctrl=0", a_out_valid, a_out_ctrl); end
        tests_run++; if (a_out_data !== {8{16'h0051}}) begin tests_failed++; $display("FAIL reclear_data_kept: got %0h exp %0h", a_out_data, {8{16'h0051}}); end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_noskid();
        test_saturation();
        test_reset_clears();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
